// File: rtl/reservation_station.sv
// Single-queue reservation station for the ALU pipe: buffers renamed ops, snoops the CDB for
// operands and issues the oldest fully-ready entry, at most one per cycle.
module reservation_station #(
    parameter int unsigned ROB_ADDR_WIDTH = 4,
    parameter int unsigned NUM_ENTRIES    = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              dispatch_valid,
    output logic                              dispatch_ready,
    input  logic [3:0]                        dispatch_alu_op,
    input  logic                              dispatch_src1_ready,
    input  logic [31:0]                       dispatch_src1_value,
    input  logic [ROB_ADDR_WIDTH-1:0]         dispatch_src1_tag,
    input  logic                              dispatch_src2_ready,
    input  logic [31:0]                       dispatch_src2_value,
    input  logic [ROB_ADDR_WIDTH-1:0]         dispatch_src2_tag,
    input  logic [ROB_ADDR_WIDTH-1:0]         dispatch_dest_tag,
    input  logic                              cdb_valid,
    input  logic [ROB_ADDR_WIDTH-1:0]         cdb_tag,
    input  logic [31:0]                       cdb_data,
    output logic                              issue_valid,
    input  logic                              issue_ready,
    output logic [3:0]                        issue_alu_op,
    output logic [31:0]                       issue_src1_value,
    output logic [31:0]                       issue_src2_value,
    output logic [ROB_ADDR_WIDTH-1:0]         issue_dest_tag,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]  rs_occupancy
);
    localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
    localparam int unsigned OccW = $clog2(NUM_ENTRIES + 1);
    localparam int unsigned TagW = ROB_ADDR_WIDTH;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0] src1_rdy_q, src1_rdy_d, src2_rdy_q, src2_rdy_d;
    logic [3:0]             alu_op_q [NUM_ENTRIES];
    logic [3:0]             alu_op_d [NUM_ENTRIES];
    logic [31:0]            src1_val_q [NUM_ENTRIES];
    logic [31:0]            src1_val_d [NUM_ENTRIES];
    logic [31:0]            src2_val_q [NUM_ENTRIES];
    logic [31:0]            src2_val_d [NUM_ENTRIES];
    logic [TagW-1:0]        src1_tag_q [NUM_ENTRIES];
    logic [TagW-1:0]        src1_tag_d [NUM_ENTRIES];
    logic [TagW-1:0]        src2_tag_q [NUM_ENTRIES];
    logic [TagW-1:0]        src2_tag_d [NUM_ENTRIES];
    logic [TagW-1:0]        dest_tag_q [NUM_ENTRIES];
    logic [TagW-1:0]        dest_tag_d [NUM_ENTRIES];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];
    logic [OccW-1:0]        occ_q, occ_d;

    logic [NUM_ENTRIES-1:0] cand, sel_oh;
    logic [IdxW-1:0]        sel_idx, alloc_idx;
    logic                   any_cand, any_free, dispatch_fire, issue_fire;

    always_comb begin
        cand     = valid_q & src1_rdy_q & src2_rdy_q;
        any_cand = |cand;
        sel_oh   = cand;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (cand[j] && older_q[j][i]) sel_oh[i] = 1'b0;
            end
        end
        sel_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_oh[i]) sel_idx = IdxW'(i);
        end
        any_free  = |(~valid_q);
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IdxW'(i);
        end
    end

    always_comb begin
        dispatch_ready   = !reset && any_free;
        issue_valid      = any_cand && !flush;
        issue_alu_op     = issue_valid ? alu_op_q[sel_idx]   : '0;
        issue_src1_value = issue_valid ? src1_val_q[sel_idx] : '0;
        issue_src2_value = issue_valid ? src2_val_q[sel_idx] : '0;
        issue_dest_tag   = issue_valid ? dest_tag_q[sel_idx] : '0;
        rs_occupancy     = occ_q;
        issue_fire       = issue_valid && issue_ready;
        dispatch_fire    = dispatch_valid && dispatch_ready && !flush;
    end

    always_comb begin
        valid_d    = valid_q;
        src1_rdy_d = src1_rdy_q;
        src2_rdy_d = src2_rdy_q;
        alu_op_d   = alu_op_q;
        src1_val_d = src1_val_q;
        src2_val_d = src2_val_q;
        src1_tag_d = src1_tag_q;
        src2_tag_d = src2_tag_q;
        dest_tag_d = dest_tag_q;
        older_d    = older_q;
        occ_d      = '0;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && cdb_valid && !src1_rdy_q[i] && cdb_tag == src1_tag_q[i]) begin
                src1_rdy_d[i] = 1'b1;
                src1_val_d[i] = cdb_data;
            end
            if (valid_q[i] && cdb_valid && !src2_rdy_q[i] && cdb_tag == src2_tag_q[i]) begin
                src2_rdy_d[i] = 1'b1;
                src2_val_d[i] = cdb_data;
            end
        end

        if (issue_fire) valid_d[sel_idx] = 1'b0;

        if (dispatch_fire) begin
            valid_d[alloc_idx]    = 1'b1;
            alu_op_d[alloc_idx]   = dispatch_alu_op;
            src1_tag_d[alloc_idx] = dispatch_src1_tag;
            src2_tag_d[alloc_idx] = dispatch_src2_tag;
            dest_tag_d[alloc_idx] = dispatch_dest_tag;
            src1_rdy_d[alloc_idx] = dispatch_src1_ready;
            src1_val_d[alloc_idx] = dispatch_src1_value;
            src2_rdy_d[alloc_idx] = dispatch_src2_ready;
            src2_val_d[alloc_idx] = dispatch_src2_value;
            // Capture a broadcast of a not-yet-ready source in the dispatch cycle itself
            if (!dispatch_src1_ready && cdb_valid && cdb_tag == dispatch_src1_tag) begin
                src1_rdy_d[alloc_idx] = 1'b1;
                src1_val_d[alloc_idx] = cdb_data;
            end
            if (!dispatch_src2_ready && cdb_valid && cdb_tag == dispatch_src2_tag) begin
                src2_rdy_d[alloc_idx] = 1'b1;
                src2_val_d[alloc_idx] = cdb_data;
            end
            older_d[alloc_idx] = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IdxW'(i) != alloc_idx) older_d[i][alloc_idx] = 1'b1;
            end
        end

        if (flush) valid_d = '0;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occ_d = occ_d + OccW'(valid_d[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            occ_q      <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                alu_op_q[i]   <= '0;
                src1_val_q[i] <= '0;
                src2_val_q[i] <= '0;
                src1_tag_q[i] <= '0;
                src2_tag_q[i] <= '0;
                dest_tag_q[i] <= '0;
                older_q[i]    <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            src1_rdy_q <= src1_rdy_d;
            src2_rdy_q <= src2_rdy_d;
            occ_q      <= occ_d;
            alu_op_q   <= alu_op_d;
            src1_val_q <= src1_val_d;
            src2_val_q <= src2_val_d;
            src1_tag_q <= src1_tag_d;
            src2_tag_q <= src2_tag_d;
            dest_tag_q <= dest_tag_d;
            older_q    <= older_d;
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a per-cycle vector table for the basic flows, then
// hand-written sequences for full/age ordering, flush and asynchronous reset.
module tb_reservation_station;
    logic        clock, reset, flush;
    logic        dispatch_valid, dispatch_ready;
    logic [3:0]  dispatch_alu_op;
    logic        dispatch_src1_ready, dispatch_src2_ready;
    logic [31:0] dispatch_src1_value, dispatch_src2_value;
    logic [3:0]  dispatch_src1_tag, dispatch_src2_tag, dispatch_dest_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_alu_op, issue_dest_tag;
    logic [31:0] issue_src1_value, issue_src2_value;
    logic [2:0]  rs_occupancy;

    int errors = 0;
    int checks = 0;

    reservation_station #(.ROB_ADDR_WIDTH(4), .NUM_ENTRIES(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_alu_op(dispatch_alu_op),
        .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src1_value(dispatch_src1_value),
        .dispatch_src1_tag(dispatch_src1_tag),
        .dispatch_src2_ready(dispatch_src2_ready), .dispatch_src2_value(dispatch_src2_value),
        .dispatch_src2_tag(dispatch_src2_tag),
        .dispatch_dest_tag(dispatch_dest_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_alu_op(issue_alu_op), .issue_src1_value(issue_src1_value),
        .issue_src2_value(issue_src2_value), .issue_dest_tag(issue_dest_tag),
        .rs_occupancy(rs_occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        dv;
        logic [3:0]  op;
        logic        s1r;
        logic [31:0] s1v;
        logic [3:0]  s1t;
        logic        s2r;
        logic [31:0] s2v;
        logic [3:0]  s2t;
        logic [3:0]  dt;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cd;
        logic        ir;
        logic        fl;
        logic        eiv;
        logic [3:0]  eop;
        logic [31:0] es1;
        logic [31:0] es2;
        logic [3:0]  etag;
        logic        edr;
        logic [2:0]  eocc;
    } vec_t;

    localparam int NumVec = 23;
    vec_t tbl [NumVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; dispatch_valid = 1'b0; dispatch_alu_op = '0;
        dispatch_src1_ready = 1'b0; dispatch_src1_value = '0; dispatch_src1_tag = '0;
        dispatch_src2_ready = 1'b0; dispatch_src2_value = '0; dispatch_src2_tag = '0;
        dispatch_dest_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        issue_ready = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic s1r, input logic [31:0] s1v,
                        input logic [3:0] s1t, input logic s2r, input logic [31:0] s2v,
                        input logic [3:0] s2t, input logic [3:0] dt);
        dispatch_valid = 1'b1; dispatch_alu_op = op;
        dispatch_src1_ready = s1r; dispatch_src1_value = s1v; dispatch_src1_tag = s1t;
        dispatch_src2_ready = s2r; dispatch_src2_value = s2v; dispatch_src2_tag = s2t;
        dispatch_dest_tag = dt;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] d);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    endtask

    task automatic chk_all(input string p, input logic eiv, input logic [3:0] eop,
                           input logic [31:0] es1, input logic [31:0] es2,
                           input logic [3:0] etag, input logic edr, input logic [2:0] eocc);
        chk({p, "_issue_valid"}, 32'(issue_valid), 32'(eiv));
        chk({p, "_alu_op"}, 32'(issue_alu_op), 32'(eop));
        chk({p, "_src1"}, issue_src1_value, es1);
        chk({p, "_src2"}, issue_src2_value, es2);
        chk({p, "_dest_tag"}, 32'(issue_dest_tag), 32'(etag));
        chk({p, "_dispatch_ready"}, 32'(dispatch_ready), 32'(edr));
        chk({p, "_occupancy"}, 32'(rs_occupancy), 32'(eocc));
    endtask

    initial begin
        // dv op s1r s1v s1t s2r s2v s2t dt | cv ct cd | ir fl | eiv eop es1 es2 etag edr eocc
        tbl[0]  = '{1'b1, 4'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[1]  = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b1, 4'd0, 32'd5, 32'd7, 4'd3, 1'b1, 3'd1};
        tbl[2]  = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[3]  = '{1'b1, 4'd1, 1'b0, 32'd0, 4'd2, 1'b1, 32'd9, 4'd0, 4'd4, 1'b0, 4'd0, 32'd0,
                    1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd1};
        tbl[5]  = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b1, 4'd2,
                    32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd1};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b1, 4'd1, 32'hDEADBEEF, 32'd9, 4'd4, 1'b1, 3'd1};
        tbl[7]  = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[8]  = '{1'b1, 4'd2, 1'b1, 32'd11, 4'd0, 1'b0, 32'd0, 4'd6, 4'd5, 1'b1, 4'd6,
                    32'h12345678, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b1, 4'd2, 32'd11, 32'h12345678, 4'd5, 1'b1, 3'd1};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[11] = '{1'b1, 4'd3, 1'b0, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0, 4'd8, 1'b0, 4'd0, 32'd0,
                    1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[12] = '{1'b1, 4'd4, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 4'd7, 4'd9, 1'b0, 4'd0, 32'd0,
                    1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd1};
        tbl[13] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b1, 4'd7, 32'd100,
                    1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd2};
        tbl[14] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b0, 1'b0, 1'b1, 4'd3, 32'd100, 32'd1, 4'd8, 1'b1, 3'd2};
        tbl[15] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b1, 4'd3, 32'd100, 32'd1, 4'd8, 1'b1, 3'd2};
        tbl[16] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b1, 4'd4, 32'd2, 32'd100, 4'd9, 1'b1, 3'd1};
        tbl[17] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[18] = '{1'b1, 4'd5, 1'b0, 32'd0, 4'd10, 1'b0, 32'd0, 4'd10, 4'd1, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};
        tbl[19] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b1, 4'd10, 32'h55,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd1};
        tbl[20] = '{1'b1, 4'd6, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd2, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b1, 4'd5, 32'h55, 32'h55, 4'd1, 1'b1, 3'd1};
        tbl[21] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b1, 4'd6, 32'd3, 32'd4, 4'd2, 1'b1, 3'd1};
        tbl[22] = '{1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0,
                    1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0};

        reset = 1'b1;
        idle();
        #1;
        chk_all("reset", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 3'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_reset_dispatch_ready", 32'(dispatch_ready), 32'd1);

        for (int k = 0; k < NumVec; k++) begin
            @(negedge clock);
            flush = tbl[k].fl; issue_ready = tbl[k].ir;
            dispatch_valid = tbl[k].dv; dispatch_alu_op = tbl[k].op;
            dispatch_src1_ready = tbl[k].s1r; dispatch_src1_value = tbl[k].s1v;
            dispatch_src1_tag = tbl[k].s1t;
            dispatch_src2_ready = tbl[k].s2r; dispatch_src2_value = tbl[k].s2v;
            dispatch_src2_tag = tbl[k].s2t; dispatch_dest_tag = tbl[k].dt;
            cdb_valid = tbl[k].cv; cdb_tag = tbl[k].ct; cdb_data = tbl[k].cd;
            #1;
            chk_all($sformatf("vec%0d", k), tbl[k].eiv, tbl[k].eop, tbl[k].es1, tbl[k].es2,
                    tbl[k].etag, tbl[k].edr, tbl[k].eocc);
        end

        // Fill every entry with ops waiting on src1 tags 12..15
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); idle();
            disp(4'd7, 1'b0, 32'd0, 4'(12 + i), 1'b1, 32'(i), 4'd0, 4'(i));
            #1;
            chk($sformatf("fill%0d_dispatch_ready", i), 32'(dispatch_ready), 32'd1);
        end
        @(negedge clock); idle(); cdb(4'd14, 32'h77);
        #1;
        chk_all("full", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 3'd4);
        // Entry 2 issues; an offer this cycle must be refused
        @(negedge clock); idle(); issue_ready = 1'b1;
        disp(4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd13);
        #1;
        chk_all("full_issue", 1'b1, 4'd7, 32'h77, 32'd2, 4'd2, 1'b0, 3'd4);
        // Young ready entry lands in slot 2 while entry 3 wakes: entry 3 is older
        @(negedge clock); idle(); issue_ready = 1'b1;
        disp(4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd11);
        cdb(4'd15, 32'h33);
        #1;
        chk_all("refill", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd3);
        @(negedge clock); idle(); issue_ready = 1'b1;
        #1;
        chk_all("age_old", 1'b1, 4'd7, 32'h33, 32'd3, 4'd3, 1'b0, 3'd4);
        @(negedge clock); idle(); issue_ready = 1'b1;
        #1;
        chk_all("age_young", 1'b1, 4'd9, 32'd1, 32'd1, 4'd11, 1'b1, 3'd3);
        @(negedge clock); idle(); cdb(4'd12, 32'd5);
        disp(4'd1, 1'b0, 32'd0, 4'd9, 1'b1, 32'd1, 4'd0, 4'd12);
        #1;
        chk_all("pre_flush", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd2);
        // Flush with 3 valid entries, entry 0 ready, a dispatch and issue_ready all at once
        @(negedge clock); idle(); flush = 1'b1; issue_ready = 1'b1;
        disp(4'd2, 1'b1, 32'd8, 4'd0, 1'b1, 32'd8, 4'd0, 4'd14);
        #1;
        chk_all("flush", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd3);
        @(negedge clock); idle(); issue_ready = 1'b1;
        #1;
        chk_all("post_flush", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0);
        @(negedge clock); idle(); issue_ready = 1'b1;
        #1;
        chk_all("post_flush2", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0);

        // Asynchronous reset in the middle of a presented issue
        @(negedge clock); idle();
        disp(4'hA, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 4'd6);
        @(negedge clock); idle();
        #1;
        chk_all("pre_reset", 1'b1, 4'hA, 32'h11, 32'h22, 4'd6, 1'b1, 3'd1);
        #2 reset = 1'b1;
        #1;
        chk_all("mid_reset", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 3'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_all("after_reset", 1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
